gf180mcu_fd_sc_mcu9t5v0__andn_pipe: RTL and testbench
=====================================================

# gf180mcu_fd_sc_mcu9t5v0__andn_pipe

Parametrised, pipelined N-input AND reduction for the 9-track 5V0 library: the registered successor to the fixed four-input AND cells. A WIDTH-bit input word is reduced through a tree of four-input AND levels, with one register per level and a valid bit travelling alongside. An optional frame accumulator ANDs successive results until a LAST-marked beat. Instantiated in MCU glue logic where wide all-ones detection must close timing at the 5V0 corner.

## Interface
- WIDTH, 4: number of input bits; legal range 2..64.
- LEVELS, derived = ceil(log4(WIDTH)), minimum 1: tree depth, equal to the pipeline latency in cycles.
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  data word to reduce.
- AV  input  1  A is valid this cycle.
- LAST  input  1  qualifies an AV beat as the final beat of a frame.
- Z  output  1  registered AND of all WIDTH bits of the beat that has reached the output.
- ZV  output  1  Z updated this cycle; a one-cycle pulse per accepted beat.
- ACC  output  1  AND of every Z result in the most recently completed frame.
- ACCV  output  1  ACC updated this cycle; a one-cycle pulse.
- VDD, VSS  inout  1  present only under USE_POWER_PINS, as for every cell.

## Operation
- Level 0 splits A into ceil(WIDTH/4) groups of four. Unused leaf inputs are tied to 1, so padding never forces a 0.
- Each level ANDs groups of four from the level below and stores the result in that level's register. The last level holds a single bit, which drives Z.
- Each level's valid bit is a copy of the previous level's valid bit, delayed by one cycle. The valid bit at level 0 is AV.
- Each data register loads only when its incoming valid bit is 1. When it is 0 the register holds.
- Consequence: Z keeps the last valid result indefinitely. ZV is the final-level valid bit.
- LAST travels down the valid pipeline and is meaningful only on AV beats.
- Accumulator: an internal register `run` resets to 1.
  - On each ZV beat, `run_next = run & Z_new`.
  - If that beat carries LAST: ACC <= run_next, ACCV = 1 for one cycle, and `run` <= 1.
  - Otherwise `run` <= run_next.
- A frame of a single LAST beat gives ACC = Z of that beat.
- There is no backpressure. A beat can be accepted every cycle, so full throughput is 1 beat per clock.

## Timing
- Reset values: Z = 0, ZV = 0, ACC = 0, ACCV = 0. All pipeline valid bits = 0. `run` = 1.
- Latency: a beat with AV = 1 in cycle t produces ZV = 1 in cycle t + LEVELS.
  - WIDTH 2..4: 1 cycle. WIDTH 5..16: 2 cycles. WIDTH 17..64: 3 cycles.
- ACC and ACCV update in the same cycle as the ZV of the LAST beat. There is no extra latency.
- Back-to-back LAST beats: each closes its own one-beat frame. ACCV pulses on consecutive cycles.
- RST asserted mid-frame or while beats are in flight:
  - All in-flight beats are discarded and no ZV is generated for them.
  - The partial frame is dropped and `run` returns to 1.
  - RST takes priority over AV in the same cycle.
- AV = 1 with RST = 1: the beat is ignored.
- Timing arcs CLK -> Z, ZV, ACC, ACCV, with setup/hold checks on A, AV, LAST and RST, sit in the specify block inside `ifndef FUNCTIONAL`. All delay values are 1.0 placeholders until characterisation.

## Configuration
- Macro: GF180MCU_FD_SC_MCU9T5V0__ANDN_PIPE_ACC_EN.
- Defined: the frame accumulator is built and behaves as described in Operation.
- Undefined:
  - No accumulator flops are built.
  - LAST is ignored.
  - ACC and ACCV are tied to 0.
  - Z, ZV, latency and reset behaviour are identical to the defined case.

## Test plan
- WIDTH=4, RST held 2 cycles, then A=4'hF with AV=1 in cycle 0 -> cycle 1: Z=1, ZV=1. Cycle 2: ZV=0, Z holds 1.
- WIDTH=16, 8 beats streamed every cycle (A=16'hFFFF, 16'hFFFE, alternating) -> ZV high for 8 cycles starting 2 cycles after the first AV; Z sequence 1,0,1,0,…
- WIDTH=7, A=7'h7F -> Z=1; A=7'h3F -> Z=0. Padding leaves do not mask bit 6.
- ACC_EN, WIDTH=4, frame of {F, F, F+LAST} -> ACC=1 with ACCV pulse at the third ZV. Next frame {F, 7+LAST} -> ACC=0. Two consecutive LAST-only beats of F -> ACCV pulses on adjacent cycles, ACC=1 both times.
- ACC_EN, WIDTH=64, two beats of a frame in flight, RST pulsed 1 cycle -> no ZV or ACCV for them, all outputs 0. Next frame {all-ones+LAST} -> ACC=1.
- ACC_EN undefined: repeat the frame test -> ACC=0 and ACCV=0 throughout, Z/ZV unchanged.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__andn_pipe
// Pipelined WIDTH-input AND reduction built from four-input AND levels,
// one register per level, with a valid bit running alongside the data.
// Optional frame accumulator, built only when
// GF180MCU_FD_SC_MCU9T5V0__ANDN_PIPE_ACC_EN is defined; otherwise ACC/ACCV
// are tied low and LAST is ignored.
// USE_POWER_PINS adds VDD/VSS; FUNCTIONAL drops the timing arcs.
module gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(
  parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic             AV,
  input  logic             LAST,
  output logic             Z,
  output logic             ZV,
  output logic             ACC,
  output logic             ACCV
);

  // Tree depth: smallest L >= 1 with 4**L >= WIDTH.
  function automatic int clog4(input int w);
    int l;
    int c;
    l = 1;
    c = 4;
    while (c < w) begin
      c = c * 4;
      l = l + 1;
    end
    return l;
  endfunction

  // Number of four-input nodes stored in level l's register.
  function automatic int nodes(input int l);
    int d;
    d = 4;
    for (int i = 0; i < l; i++) d = d * 4;
    return (WIDTH + d - 1) / d;
  endfunction

  localparam int LEVELS = clog4(WIDTH);

  // vld_pipe[0] is the incoming beat; vld_pipe[l] qualifies level l's input.
  logic [LEVELS:1] vld_q;
  logic [LEVELS:0] vld_pipe;

  assign vld_pipe = {vld_q, AV};

  // Valid shift register; reset flushes every in-flight beat.
  always_ff @(posedge CLK) begin
    if (RST) vld_q <= '0;
    else     vld_q <= vld_pipe[LEVELS-1:0];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N  = nodes(l);
    localparam int NI = (l == 0) ? WIDTH : nodes(l - 1);

    logic [NI-1:0]  src;
    logic [4*N-1:0] din;
    logic [N-1:0]   q;

    if (l == 0) begin : g_src0
      assign src = A;
    end else begin : g_srcn
      assign src = g_lvl[l-1].q;
    end

    // Pad unused leaves with 1 so they never mask a real 0.
    always_comb begin
      din          = '1;
      din[NI-1:0]  = src;
    end

    // Level register loads only for a valid beat, otherwise holds.
    always_ff @(posedge CLK) begin
      if (RST) q <= '0;
      else if (vld_pipe[l]) begin
        for (int n = 0; n < N; n++) q[n] <= &din[4*n +: 4];
      end
    end
  end

  assign Z  = g_lvl[LEVELS-1].q[0];
  assign ZV = vld_pipe[LEVELS];

`ifdef GF180MCU_FD_SC_MCU9T5V0__ANDN_PIPE_ACC_EN
  // lst_pipe[l] is the LAST flag matching the beat at vld_pipe[l].
  wire [LEVELS-1:0] lst_pipe;
  assign lst_pipe[0] = LAST;

  for (genvar l = 1; l < LEVELS; l++) begin : g_lst
    logic r;
    // LAST follows its beat down the tree.
    always_ff @(posedge CLK) begin
      if (RST) r <= 1'b0;
      else     r <= vld_pipe[l-1] & lst_pipe[l-1];
    end
    assign lst_pipe[l] = r;
  end

  logic run, acc_q, accv_q;
  logic z_nxt, run_nxt;

  // Accumulate using the value Z is about to take, so ACC lands with ZV.
  assign z_nxt   = &g_lvl[LEVELS-1].din;
  assign run_nxt = run & z_nxt;

  // Frame accumulator: close on LAST, otherwise keep ANDing results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run    <= 1'b1;
      acc_q  <= 1'b0;
      accv_q <= 1'b0;
    end else begin
      accv_q <= 1'b0;
      if (vld_pipe[LEVELS-1]) begin
        if (lst_pipe[LEVELS-1]) begin
          acc_q  <= run_nxt;
          accv_q <= 1'b1;
          run    <= 1'b1;
        end else begin
          run    <= run_nxt;
        end
      end
    end
  end

  assign ACC  = acc_q;
  assign ACCV = accv_q;
`else
  logic unused_last;
  assign unused_last = LAST;
  assign ACC  = 1'b0;
  assign ACCV = 1'b0;
`endif

`ifndef FUNCTIONAL
  // Nominal arcs until characterisation.
  specify
    (CLK => Z)    = (1.0, 1.0);
    (CLK => ZV)   = (1.0, 1.0);
    (CLK => ACC)  = (1.0, 1.0);
    (CLK => ACCV) = (1.0, 1.0);
    $setup(A,    posedge CLK, 1.0);
    $hold (posedge CLK, A,    1.0);
    $setup(AV,   posedge CLK, 1.0);
    $hold (posedge CLK, AV,   1.0);
    $setup(LAST, posedge CLK, 1.0);
    $hold (posedge CLK, LAST, 1.0);
    $setup(RST,  posedge CLK, 1.0);
    $hold (posedge CLK, RST,  1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// Bench for gf180mcu_fd_sc_mcu9t5v0__andn_pipe: four widths (4, 7, 16, 64)
// share one input stream; directed vector tables plus hand sequences for
// streaming, frame accumulation and mid-flight reset.
module tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe;

`ifdef GF180MCU_FD_SC_MCU9T5V0__ANDN_PIPE_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, av, last;
  logic [63:0] a;
  wire  [3:0]  z, zv, acc, accv;

  int pass_cnt = 0;
  int total    = 0;
  int lat [4]  = '{1, 2, 2, 3};
  int wd  [4]  = '{4, 7, 16, 64};

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(4)) u4 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(a[3:0]), .AV(av), .LAST(last),
    .Z(z[0]), .ZV(zv[0]), .ACC(acc[0]), .ACCV(accv[0]));

  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(7)) u7 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(a[6:0]), .AV(av), .LAST(last),
    .Z(z[1]), .ZV(zv[1]), .ACC(acc[1]), .ACCV(accv[1]));

  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(16)) u16 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(a[15:0]), .AV(av), .LAST(last),
    .Z(z[2]), .ZV(zv[2]), .ACC(acc[2]), .ACCV(accv[2]));

  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(64)) u64 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(a), .AV(av), .LAST(last),
    .Z(z[3]), .ZV(zv[3]), .ACC(acc[3]), .ACCV(accv[3]));

  typedef struct {
    logic [63:0] a;
    logic [3:0]  ez;   // expected Z for {w64, w16, w7, w4}
    string       nm;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic       av, last;
    logic       ezv, ez, eaccv, eacc;
  } fb_t;

  vec_t vecs [10];
  fb_t  fr   [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, "ones"};
    vecs[1] = '{64'h0000_0000_0000_0000, 4'b0000, "zero"};
    vecs[2] = '{64'h0000_0000_0000_007F, 4'b0011, "h7f"};
    vecs[3] = '{64'h0000_0000_0000_003F, 4'b0001, "h3f"};
    vecs[4] = '{64'h0000_0000_0000_FFFF, 4'b0111, "hffff"};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFE, 4'b0000, "bit0lo"};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 4'b0111, "bit63lo"};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFBF, 4'b0001, "bit6lo"};
    vecs[8] = '{64'h0000_0000_0000_FFF7, 4'b0000, "bit3lo"};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, "ones2"};

    //          a     av    last  ezv   ez    eaccv eacc
    fr[0] = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    fr[1] = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    fr[2] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fr[3] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    fr[4] = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fr[5] = '{4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    fr[6] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fr[7] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fr[8] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held two cycles.
    rst = 1'b1; av = 1'b0; last = 1'b0; a = '0;
    step(); step();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset z w%0d", wd[d]),    z[d],    1'b0);
      chk($sformatf("reset zv w%0d", wd[d]),   zv[d],   1'b0);
      chk($sformatf("reset acc w%0d", wd[d]),  acc[d],  1'b0);
      chk($sformatf("reset accv w%0d", wd[d]), accv[d], 1'b0);
    end
    rst = 1'b0;

    // Single beats: ZV at exactly the width's latency, Z holds afterwards.
    for (int v = 0; v < 10; v++) begin
      a = vecs[v].a; av = 1'b1;
      step();
      av = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (k > 1) step();
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("%s zv w%0d k%0d", vecs[v].nm, wd[d], k), zv[d], k == lat[d]);
          if (k >= lat[d])
            chk($sformatf("%s z w%0d k%0d", vecs[v].nm, wd[d], k), z[d], vecs[v].ez[d]);
          chk($sformatf("%s accv w%0d k%0d", vecs[v].nm, wd[d], k), accv[d], 1'b0);
        end
      end
    end

    // Full-throughput stream on WIDTH=16: alternate ones / bit0 low.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        a  = {48'hFFFF_FFFF_FFFF, (c % 2 == 1) ? 16'hFFFE : 16'hFFFF};
        av = 1'b1;
      end else begin
        av = 1'b0;
      end
      step();
      chk($sformatf("stream zv c%0d", c + 1), zv[2], (c + 1 >= 2) && (c + 1 <= 9));
      if ((c + 1 >= 2) && (c + 1 <= 9))
        chk($sformatf("stream z c%0d", c + 1), z[2], ((c + 1 - 2) % 2) == 0);
    end
    av = 1'b0;

    // Frame accumulation on WIDTH=4 from a clean accumulator.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = {60'h0, fr[i].a}; av = fr[i].av; last = fr[i].last;
      step();
      chk($sformatf("frame zv b%0d", i),   zv[0],   fr[i].ezv);
      chk($sformatf("frame z b%0d", i),    z[0],    fr[i].ez);
      chk($sformatf("frame accv b%0d", i), accv[0], ACC_ON & fr[i].eaccv);
      chk($sformatf("frame acc b%0d", i),  acc[0],  ACC_ON & fr[i].eacc);
    end
    av = 1'b0; last = 1'b0;
    step(); step(); step();

    // WIDTH=64: a zero beat poisons run, a ones beat sets Z, then reset
    // lands with two beats in flight and an AV beat in the reset cycle.
    a = '0; av = 1'b1;
    step(); av = 1'b0; step(); step();
    chk("w64 zero beat zv", zv[3], 1'b1);
    chk("w64 zero beat z",  z[3],  1'b0);
    a = '1; av = 1'b1;
    step(); av = 1'b0; step(); step();
    chk("w64 ones beat zv", zv[3], 1'b1);
    chk("w64 ones beat z",  z[3],  1'b1);
    a = '1; av = 1'b1;
    step(); step();
    rst = 1'b1; last = 1'b1;
    step();
    rst = 1'b0; av = 1'b0; last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst flush zv k%0d", k),   zv[3],   1'b0);
      chk($sformatf("rst flush z k%0d", k),    z[3],    1'b0);
      chk($sformatf("rst flush acc k%0d", k),  acc[3],  1'b0);
      chk($sformatf("rst flush accv k%0d", k), accv[3], 1'b0);
      step();
    end
    a = '1; av = 1'b1; last = 1'b1;
    step();
    av = 1'b0; last = 1'b0;
    step();
    chk("w64 post-rst zv k2", zv[3], 1'b0);
    step();
    chk("w64 post-rst zv k3",   zv[3],   1'b1);
    chk("w64 post-rst z k3",    z[3],    1'b1);
    chk("w64 post-rst accv k3", accv[3], ACC_ON);
    chk("w64 post-rst acc k3",  acc[3],  ACC_ON);
    step();
    chk("w64 post-rst accv k4", accv[3], 1'b0);
    chk("w64 post-rst acc k4",  acc[3],  ACC_ON);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
